// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader for the 64-word instruction memory.
// Stream: one count byte N, then 4*N big-endian bytes written to words 0..N-1.
// The processor is held in reset until the whole image has been written.
module imem_loader #(
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_BYTE  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    localparam logic [7:0] DEPTH_B = 8'(DEPTH);

    state_t      state_r;
    logic [7:0]  count_r;
    logic [7:0]  word_cnt_r;
    logic [1:0]  byte_idx_r;
    logic [31:0] word_r;
    logic        accept_s;

    // A byte is consumed only when the host offers it and the loader is ready.
    assign accept_s = in_valid & in_ready;

    // Loader FSM; every output is a flop updated alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= S_IDLE;
            count_r    <= 8'd0;
            word_cnt_r <= 8'd0;
            byte_idx_r <= 2'd0;
            word_r     <= 32'd0;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    state_r  <= S_COUNT;
                    in_ready <= 1'b1;
                    imem_we  <= 1'b0;
                end
                S_COUNT: begin
                    imem_we <= 1'b0;
                    if (accept_s) begin
                        count_r <= in_data;
                        if (in_data == 8'd0) begin
                            state_r   <= S_DONE;
                            in_ready  <= 1'b0;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else if (in_data > DEPTH_B) begin
                            state_r  <= S_ERR;
                            in_ready <= 1'b0;
                            error    <= 1'b1;
                        end else begin
                            state_r    <= S_BYTE;
                            byte_idx_r <= 2'd0;
                            word_cnt_r <= 8'd0;
                            imem_addr  <= '0;
                        end
                    end else begin
                        state_r <= S_COUNT;
                    end
                end
                S_BYTE: begin
                    imem_we <= 1'b0;
                    if (accept_s) begin
                        // Big-endian: earlier bytes shift towards the MSB.
                        word_r     <= {word_r[23:0], in_data};
                        byte_idx_r <= byte_idx_r + 2'd1;
                        if (byte_idx_r == 2'd3) begin
                            state_r    <= S_WRITE;
                            in_ready   <= 1'b0;
                            imem_we    <= 1'b1;
                            imem_wdata <= {word_r[23:0], in_data};
                        end else begin
                            state_r <= S_BYTE;
                        end
                    end else begin
                        state_r <= S_BYTE;
                    end
                end
                S_WRITE: begin
                    imem_we    <= 1'b0;
                    word_cnt_r <= word_cnt_r + 8'd1;
                    // Wraps after the last word, but the FSM is in DONE by then.
                    imem_addr  <= imem_addr + ADDR_WIDTH'(1);
                    if ((word_cnt_r + 8'd1) == count_r) begin
                        state_r   <= S_DONE;
                        done      <= 1'b1;
                        cpu_reset <= 1'b0;
                        in_ready  <= 1'b0;
                    end else begin
                        state_r    <= S_BYTE;
                        byte_idx_r <= 2'd0;
                        in_ready   <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_r  <= S_DONE;
                    in_ready <= 1'b0;
                    imem_we  <= 1'b0;
                end
                S_ERR: begin
                    state_r  <= S_ERR;
                    in_ready <= 1'b0;
                    imem_we  <= 1'b0;
                end
                default: begin
                    state_r  <= S_IDLE;
                    in_ready <= 1'b0;
                    imem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a byte-stream model predicts the imem
// writes, a monitor pops and compares them as imem_we pulses.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic        imem_we;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        error;

    typedef struct {
        logic [5:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] stim_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         rel_cyc = 0;

    imem_loader #(.ADDR_WIDTH(6), .DEPTH(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Monitor: every write strobe must match the oldest predicted write.
    always @(negedge clk) begin
        if (!reset && imem_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0d data %h, none expected", imem_addr, imem_wdata);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                chk("write_addr", 32'(imem_addr), 32'(w.a));
                chk("write_data", imem_wdata, w.d);
            end
        end
    end

    // Reference model: N = first byte; N>64 is an error with no writes,
    // otherwise each complete group of four bytes is one big-endian word.
    task automatic build_expect(output bit is_err, output int n);
        wr_t w;
        n = int'(stim_q[0]);
        is_err = (n > 64);
        if (!is_err) begin
            for (int k = 0; k < n; k++) begin
                if (4 * k + 4 <= stim_q.size() - 1) begin
                    w.a = 6'(k);
                    w.d = {stim_q[4*k+1], stim_q[4*k+2], stim_q[4*k+3], stim_q[4*k+4]};
                    exp_q.push_back(w);
                end
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_imem_we", 32'(imem_we), 32'd0);
        chk("rst_imem_addr", 32'(imem_addr), 32'd0);
        chk("rst_imem_wdata", imem_wdata, 32'd0);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        exp_q.delete();
        reset = 1'b0;
        rel_cyc = cyc;
    endtask

    // Offer one byte after a gap of idle cycles; returns at the negedge after acceptance.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        in_valid = 1'b1;
        in_data = b;
        waited = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready %0d expected 1", in_ready);
            in_valid = 1'b0;
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic send_all(input int gap_lo, input int gap_hi);
        foreach (stim_q[i]) send_byte(stim_q[i], int'($urandom_range(gap_hi, gap_lo)));
        in_valid = 1'b0;
    endtask

    task automatic finish_load(input bit is_err, input int n, input bit exact);
        int waited;
        waited = 0;
        while (!(done || error) && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (is_err) begin
            chk("err_error", 32'(error), 32'd1);
            chk("err_cpu_reset", 32'(cpu_reset), 32'd1);
            chk("err_done", 32'(done), 32'd0);
        end else begin
            chk("done_done", 32'(done), 32'd1);
            chk("done_cpu_reset", 32'(cpu_reset), 32'd0);
            chk("done_error", 32'(error), 32'd0);
            if (exact) chk("done_latency", 32'(cyc - rel_cyc), 32'(2 + 5 * n));
        end
        chk("end_in_ready", 32'(in_ready), 32'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // Keep offering bytes after a terminal state; nothing may be accepted.
    task automatic hold_valid(input int cycles);
        int bad;
        bad = 0;
        in_valid = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            in_data = 8'($urandom);
            @(negedge clk);
            if (in_ready || imem_we) bad++;
        end
        in_valid = 1'b0;
        chk("terminal_no_accept", 32'(bad), 32'd0);
    endtask

    initial begin
        bit is_err;
        int n;

        // Directed two-word load with no bubbles: exact 2+5N latency.
        apply_reset();
        stim_q = '{8'h02, 8'h00, 8'h08, 8'h40, 8'h20, 8'h00, 8'h09, 8'h48, 8'h20};
        build_expect(is_err, n);
        send_all(0, 0);
        finish_load(is_err, n, 1'b1);

        // Zero-length image completes immediately.
        apply_reset();
        stim_q = '{8'h00};
        build_expect(is_err, n);
        send_all(0, 0);
        finish_load(is_err, n, 1'b1);
        hold_valid(5);

        // Oversized count: sticky error, nothing accepted for 300 cycles.
        apply_reset();
        stim_q = '{8'h41};
        build_expect(is_err, n);
        send_all(0, 0);
        finish_load(is_err, n, 1'b0);
        hold_valid(300);
        chk("err_still_cpu_reset", 32'(cpu_reset), 32'd1);

        // Single word with three idle cycles before each byte.
        apply_reset();
        stim_q = '{8'h01, 8'hAD, 8'h09, 8'h00, 8'h01};
        build_expect(is_err, n);
        send_all(3, 3);
        finish_load(is_err, n, 1'b0);

        // Full memory, data equals word index.
        apply_reset();
        stim_q = '{8'd64};
        for (int k = 0; k < 64; k++) begin
            stim_q.push_back(8'h00);
            stim_q.push_back(8'h00);
            stim_q.push_back(8'h00);
            stim_q.push_back(8'(k));
        end
        build_expect(is_err, n);
        send_all(0, 0);
        finish_load(is_err, n, 1'b1);
        hold_valid(20);

        // Reset in the middle of word 1 of a three-word load.
        apply_reset();
        stim_q = '{8'h03, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2};
        build_expect(is_err, n);
        send_all(0, 0);
        repeat (3) @(negedge clk);
        chk("partial_drained", 32'(exp_q.size()), 32'd0);
        chk("partial_cpu_reset", 32'(cpu_reset), 32'd1);
        apply_reset();
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        stim_q = '{8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        build_expect(is_err, n);
        send_all(0, 0);
        finish_load(is_err, n, 1'b0);

        // Randomized loads with random gaps.
        for (int t = 0; t < 6; t++) begin
            apply_reset();
            stim_q = '{8'($urandom_range(8, 1))};
            for (int i = 0; i < 4 * int'(stim_q[0]); i++) stim_q.push_back(8'($urandom));
            build_expect(is_err, n);
            send_all(0, 3);
            finish_load(is_err, n, 1'b0);
        end

        // Randomized oversized counts.
        for (int t = 0; t < 3; t++) begin
            apply_reset();
            stim_q = '{8'($urandom_range(255, 65))};
            build_expect(is_err, n);
            send_all(0, 2);
            finish_load(is_err, n, 1'b0);
            hold_valid(10);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream program loader that writes the 64-word instruction memory; the imem read port sees it from the other side.
- Sits between a host byte source (UART/bench) and the imem write port.
- Holds the processor in reset until a complete program image has been written, then releases it.
- Stream format: one count byte N, then 4·N bytes (big-endian words, MSB first) written to addresses 0..N-1.

Parameters:
- ADDR_WIDTH, 6, instruction-memory address width.
- DEPTH, 64, number of instruction words; must be ≤ 255.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  host byte valid.
- in_data  input  8  host byte.
- in_ready  output  1  loader can accept a byte this cycle.
- imem_we  output  1  instruction-memory write strobe, one cycle per word.
- imem_addr  output  ADDR_WIDTH  write address.
- imem_wdata  output  32  write data.
- cpu_reset  output  1  reset to processor; high until load completes.
- done  output  1  load complete, sticky.
- error  output  1  count byte exceeded DEPTH, sticky.

Behaviour:
- One clock, reset is synchronous and active-high; clock port clk, reset port reset.
- Reset values:
  - in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0.
  - cpu_reset=1, done=0, error=0.
  - State=IDLE; word counter=0; byte index=0.
- Handshake: a byte is consumed on a posedge where in_valid & in_ready.
  - in_data is ignored otherwise.
  - in_ready is decoded from state: 1 only in COUNT and BYTE.
- States:
  - IDLE: in_ready=0. Always moves to COUNT on the next edge.
  - COUNT: on accept, latch N=in_data.
    - N=0 → DONE.
    - N>DEPTH → ERR.
    - Otherwise → BYTE with byte index=0 and imem_addr=0.
  - BYTE: on accept, shift the byte into the word register (first byte lands in [31:24], fourth in [7:0]) and increment byte index.
    - The accept of the 4th byte moves to WRITE.
  - WRITE: exactly one cycle.
    - imem_we=1; imem_wdata = assembled word; imem_addr = current word index; in_ready=0.
    - On exit, word counter and imem_addr increment.
    - If the counter reaches N → DONE, else → BYTE with byte index=0.
  - DONE: done=1, cpu_reset=0, in_ready=0, imem_we=0. Terminal until reset; further bytes are not accepted.
  - ERR: error=1, cpu_reset=1, in_ready=0, imem_we=0. Terminal until reset; no writes ever occur for that load.
- Latency:
  - 4th byte of word k accepted at edge t → imem_we high in cycle t..t+1 with addr=k.
  - For the last word, done=1 and cpu_reset=0 from edge t+1.
- Minimum load time is 2 + 5·N cycles after reset release (no bubbles).
- in_valid gaps stall BYTE/COUNT indefinitely with no state change and no write.
- imem_addr is ADDR_WIDTH bits. After writing word DEPTH-1 it wraps to 0 internally, but the FSM is already in DONE, so no extra write occurs.
- Reset mid-load: all state returns to reset values on that edge. A partially assembled word is discarded, cpu_reset stays 1, and previously written imem words are not cleared. The next stream must restart with a count byte.
- imem_wdata and imem_addr need only be valid while imem_we=1.

Test Plan:
- Reset, then stream 02, 00,08,40,20, 00,09,48,20 with in_valid held high:
  - imem_we pulses twice: addr 0 data 0x00084020, then addr 1 data 0x00094820.
  - done=1 and cpu_reset=0 exactly 12 cycles after reset release.
- Count byte 00 → done=1 and cpu_reset=0 on the edge after the accept; imem_we never asserts.
- Count byte 0x41 (65) → error=1, cpu_reset stays 1, in_ready=0, no imem_we over 300 cycles of continued in_valid.
- N=1, bytes 0xAD,0x09,0x00,0x01 with in_valid low for 3 cycles between each byte:
  - Exactly one write, addr 0 data 0xAD090001.
  - No byte accepted while in_valid=0.
- N=64 with data = word index:
  - 64 writes with addr 0..63, wdata 0..63.
  - done asserts after the 64th; in_ready stays 0 afterwards, and extra bytes are not accepted.
- N=3, assert reset after the 2nd byte of word 1:
  - Word 0 was written; no write to addr 1.
  - After reset, in_ready=0 for one cycle, then 1; a fresh stream 01,11,22,33,44 writes 0x11223344 to addr 0 and sets done.
